// File: rtl/mdu_seq.sv
//------------------------------------------------------------------------------
// Module   : mdu_seq
// Function : Iterative multiply/divide unit owning the HI/LO registers.
//            Shift-add multiply and restoring divide, one bit per clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [WIDTH-1:0]     r_opb;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_start_md;
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_qbit;
    logic [2*WIDTH-1:0]   w_prod_fin;
    logic [WIDTH-1:0]     w_quo_fin;
    logic [WIDTH-1:0]     w_rem_fin;

    assign w_start_md = (r_state == S_IDLE) && start && !op[2];
    assign w_signed   = !op[0];
    assign w_a_neg    = w_signed && a[WIDTH-1];
    assign w_b_neg    = w_signed && b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;

    // Multiply: add the multiplicand into the upper half, keeping the carry.
    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                 + {1'b0, r_opb & {WIDTH{r_prod[0]}}};

    // Divide: dividend bits shift out of r_prod MSB-first, quotient bits shift in.
    assign w_trial = {r_rem, r_prod[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_opb};
    assign w_qbit  = !w_diff[WIDTH];

    assign w_prod_fin = r_neg_q ? -r_prod : r_prod;
    assign w_quo_fin  = r_div0  ? {WIDTH{1'b1}}
                      : (r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
    // With a zero divisor the remainder path reproduces |a|, so the sign fix restores a.
    assign w_rem_fin  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_md) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_SIGN;
            S_SIGN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_md) begin
                        r_cnt    <= c_CNT_INIT;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= op[1] && (b == '0);
                        r_opb    <= w_b_mag;
                        r_prod   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_rem    <= '0;
                    end else if (start && op[2] && !op[1]) begin
                        if (op[0]) begin
                            r_lo <= a;
                        end else begin
                            r_hi <= a;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_is_div) begin
                        r_rem               <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_prod[WIDTH-1:0]   <= {r_prod[WIDTH-2:0], w_qbit};
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end
                end
                S_SIGN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fin;
                        r_lo <= w_quo_fin;
                    end else begin
                        r_hi <= w_prod_fin[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fin[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_mdu_seq
// Function : Directed self-checking bench for mdu_seq at WIDTH=32.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu_seq;

    localparam int c_W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2:0]     op;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_seq #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit interfere);
        int          cyc;
        int          bcnt;
        bit          changed;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'b010; a = ~x; b = ~y;
        hold_hi = hi; hold_lo = lo;
        cyc = 0; bcnt = 0; changed = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            if (hi !== hold_hi || lo !== hold_lo) changed = 1;
            if (interfere && cyc == 5) begin
                start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, "_hilo_stable"}, 64'(changed), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply
        do_op("mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("hold_hi", 64'(hi), 64'hFFFF_FFFF);
        do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        @(negedge clk);
        do_op("mult_minsq", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        @(negedge clk);

        // Divide
        do_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        @(negedge clk);
        do_op("divu_m7d2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 0);
        @(negedge clk);
        do_op("divu_by0", 3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        do_op("div_neg_by0", 3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        @(negedge clk);

        // MTHI / MTLO / no-op
        start = 1'b1; op = 3'b100; a = 32'hCAFE_F00D;
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
        check("mthi_busy", 64'(busy), 64'd0);
        op = 3'b101; a = 32'h1234_5678;
        @(negedge clk);
        check("mtlo_lo", 64'(lo), 64'h1234_5678);
        check("mtlo_hi_kept", 64'(hi), 64'hCAFE_F00D);
        check("mtlo_done", 64'(done), 64'd0);
        op = 3'b110; a = 32'h0;
        @(negedge clk);
        start = 1'b0;
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});

        // Ignored start while busy, then back-to-back start in the done cycle
        do_op("mult_interfere", 3'b000, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
        check("b2b_done_cycle", 64'(done), 64'd1);
        do_op("divu_b2b", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        @(negedge clk);

        // Asynchronous reset mid-operation
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) break;
        end
        check("post_rst_idle", {62'd0, busy, done}, 64'd0);
        do_op("mult_6x7", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
